// File: rtl/seq_reduce_unit.sv
// Multi-cycle OR/AND/XOR/NOR reduction engine: accepts a WIDTH-bit vector
// and folds it CHUNK bits per clock, LSB chunk first, with optional early exit.
module seq_reduce_unit #(
   parameter int WIDTH      = 8,
   parameter int CHUNK      = 2,
   parameter int EARLY_EXIT = 1,
   localparam int NCH       = WIDTH / CHUNK,
   localparam int CW        = $clog2(NCH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic [CW-1:0]    out_chunks
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [1:0] {
      MODE_OR  = 2'b00,
      MODE_AND = 2'b01,
      MODE_XOR = 2'b10,
      MODE_NOR = 2'b11
   } mode_t;

   state_t           state, state_next;
   mode_t            mode;
   logic [WIDTH-1:0] data;
   logic             acc;
   logic [CW-1:0]    idx;

   logic [CHUNK-1:0] chunk;
   logic             chunk_red;
   logic             acc_next;
   logic             forced;
   logic             finish;

   // data is shifted right each BUSY cycle, so the current chunk is always the LSBs
   always_comb begin
      chunk     = data[CHUNK-1:0];
      chunk_red = 1'b0;
      acc_next  = acc;
      forced    = 1'b0;
      case (mode)
         MODE_AND: begin
            chunk_red = &chunk;
            acc_next  = acc & chunk_red;
            forced    = (EARLY_EXIT != 0) && !acc_next;
         end
         MODE_XOR: begin
            chunk_red = ^chunk;
            acc_next  = acc ^ chunk_red;
         end
         default: begin
            chunk_red = |chunk;
            acc_next  = acc | chunk_red;
            forced    = (EARLY_EXIT != 0) && acc_next;
         end
      endcase
      finish = (idx == CW'(NCH - 1)) || forced;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = BUSY;
         BUSY:    if (finish)    state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode       <= MODE_OR;
         data       <= '0;
         acc        <= 1'b0;
         idx        <= '0;
         out_bit    <= 1'b0;
         out_chunks <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mode <= mode_t'(in_mode);
                  data <= in_data;
                  acc  <= (in_mode == MODE_AND);
                  idx  <= '0;
               end
            end
            BUSY: begin
               acc  <= acc_next;
               data <= data >> CHUNK;
               idx  <= idx + CW'(1);
               if (finish) begin
                  out_bit    <= (mode == MODE_NOR) ? ~acc_next : acc_next;
                  out_chunks <= idx + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_seq_reduce_unit.sv
// Directed table-driven bench for seq_reduce_unit: early-exit, full-length
// and single-chunk instances, plus backpressure and mid-BUSY reset sequences.
module tb_seq_reduce_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = '0;
   logic [1:0] in_mode = '0;
   logic       out_ready = 1'b0;
   logic [2:0] iv = '0;

   logic       ir0, ir1, ir2, ov0, ov1, ov2, ob0, ob1, ob2;
   logic [2:0] oc0, oc1;
   logic [0:0] oc2;

   always #5 clk = ~clk;

   seq_reduce_unit #(.WIDTH(8), .CHUNK(2), .EARLY_EXIT(1)) u_ee (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .in_data(in_data),
      .in_mode(in_mode), .out_valid(ov0), .out_ready(out_ready), .out_bit(ob0),
      .out_chunks(oc0));

   seq_reduce_unit #(.WIDTH(8), .CHUNK(2), .EARLY_EXIT(0)) u_ne (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .in_data(in_data),
      .in_mode(in_mode), .out_valid(ov1), .out_ready(out_ready), .out_bit(ob1),
      .out_chunks(oc1));

   seq_reduce_unit #(.WIDTH(4), .CHUNK(4), .EARLY_EXIT(1)) u_one (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .in_data(in_data[3:0]),
      .in_mode(in_mode), .out_valid(ov2), .out_ready(out_ready), .out_bit(ob2),
      .out_chunks(oc2));

   int   sel = 0;
   logic cur_ir, cur_ov, cur_ob;
   int   cur_oc;

   always_comb begin
      cur_ir = ir0; cur_ov = ov0; cur_ob = ob0; cur_oc = int'(oc0);
      case (sel)
         1: begin cur_ir = ir1; cur_ov = ov1; cur_ob = ob1; cur_oc = int'(oc1); end
         2: begin cur_ir = ir2; cur_ov = ov2; cur_ob = ob2; cur_oc = int'(oc2); end
         default: ;
      endcase
   end

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   typedef struct {
      int         sel;
      logic [7:0] data;
      logic [1:0] mode;
      bit         tog;
      int         exp_bit;
      int         exp_chunks;
   } vec_t;

   // Accept one request on instance t.sel; latency counts edges after accept until out_valid.
   task automatic run_txn(input vec_t t, input bit ack);
      int lat;
      @(negedge clk);
      sel = t.sel; in_data = t.data; in_mode = t.mode;
      check("in_ready_idle", int'(cur_ir), 1);
      iv = '0; iv[t.sel] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv = '0;
      if (t.tog) in_mode = ~t.mode;
      lat = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         lat++;
         if (cur_ov) break;
      end
      check("out_valid", int'(cur_ov), 1);
      check("latency", lat, t.exp_chunks);
      check("out_bit", int'(cur_ob), t.exp_bit);
      check("out_chunks", cur_oc, t.exp_chunks);
      check("in_ready_done", int'(cur_ir), 0);
      if (ack) begin
         @(negedge clk); out_ready = 1'b1;
         @(posedge clk); #1;
         check("ack_out_valid", int'(cur_ov), 0);
         check("ack_in_ready", int'(cur_ir), 1);
         @(negedge clk); out_ready = 1'b0;
      end
   endtask

   vec_t v[18];

   initial begin
      int extra;
      // sel: 0 early-exit 8/2, 1 no early-exit 8/2, 2 single-chunk 4/4
      v[0]  = '{0, 8'h00, 2'b00, 1'b0, 0, 4};
      v[1]  = '{0, 8'h04, 2'b00, 1'b0, 1, 2};
      v[2]  = '{0, 8'h04, 2'b11, 1'b0, 0, 2};
      v[3]  = '{1, 8'h04, 2'b00, 1'b0, 1, 4};
      v[4]  = '{0, 8'hFF, 2'b01, 1'b0, 1, 4};
      v[5]  = '{0, 8'hFE, 2'b01, 1'b0, 0, 1};
      v[6]  = '{0, 8'hA7, 2'b10, 1'b0, 1, 4};
      v[7]  = '{0, 8'hA6, 2'b10, 1'b0, 0, 4};
      v[8]  = '{0, 8'hA7, 2'b10, 1'b1, 1, 4};
      v[9]  = '{0, 8'h00, 2'b11, 1'b0, 1, 4};
      v[10] = '{0, 8'h7F, 2'b01, 1'b0, 0, 4};
      v[11] = '{0, 8'h80, 2'b00, 1'b0, 1, 4};
      v[12] = '{1, 8'hFE, 2'b01, 1'b0, 0, 4};
      v[13] = '{1, 8'h00, 2'b11, 1'b0, 1, 4};
      v[14] = '{2, 8'h00, 2'b00, 1'b0, 0, 1};
      v[15] = '{2, 8'h0F, 2'b01, 1'b0, 1, 1};
      v[16] = '{2, 8'h07, 2'b10, 1'b0, 1, 1};
      v[17] = '{2, 8'h00, 2'b11, 1'b1, 1, 1};

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", int'(ov0), 0);
      check("rst_out_bit", int'(ob0), 0);
      check("rst_out_chunks", int'(oc0), 0);
      check("rst_in_ready", int'(ir0), 1);
      @(negedge clk); rst = 1'b0;

      foreach (v[i]) run_txn(v[i], 1'b1);

      // Backpressure: result held, in_valid pulse ignored while in DONE
      run_txn('{0, 8'hFF, 2'b01, 1'b0, 1, 4}, 1'b0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         in_data = 8'h00; in_mode = 2'b00;
         iv[0] = (c == 1);
         @(posedge clk); #1;
         check("bp_out_valid", int'(ov0), 1);
         check("bp_out_bit", int'(ob0), 1);
         check("bp_out_chunks", int'(oc0), 4);
         check("bp_in_ready", int'(ir0), 0);
      end
      @(negedge clk); iv = '0; out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", int'(ov0), 0);
      check("bp_release_ready", int'(ir0), 1);
      @(negedge clk); out_ready = 1'b1;
      extra = 0;
      repeat (6) begin @(posedge clk); #1; if (ov0) extra++; end
      check("bp_pulse_dropped", extra, 0);
      out_ready = 1'b0;

      // Reset during the second BUSY cycle after a result that left out_bit=1
      run_txn('{0, 8'hA7, 2'b10, 1'b0, 1, 4}, 1'b1);
      @(negedge clk); in_data = 8'h00; in_mode = 2'b00; iv[0] = 1'b1;
      @(posedge clk);
      @(negedge clk); iv = '0;
      @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("abort_out_valid", int'(ov0), 0);
      check("abort_out_bit", int'(ob0), 0);
      check("abort_out_chunks", int'(oc0), 0);
      check("abort_in_ready", int'(ir0), 1);
      @(negedge clk); rst = 1'b0; out_ready = 1'b1;
      extra = 0;
      repeat (8) begin @(posedge clk); #1; if (ov0) extra++; end
      check("abort_no_result", extra, 0);
      check("abort_idle_ready", int'(ir0), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
